// File: rtl/fifo_ctrl.sv
// fifo_ctrl: control FSM, pointers, occupancy and status flags for a dual-port RAM FIFO
module fifo_ctrl #(
  parameter int RAM_DEPTH = 8,
  parameter int PTR_SIZE  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init,
  input  logic [PTR_SIZE-1:0] th_af_in,
  input  logic [PTR_SIZE-1:0] th_ae_in,
  input  logic                push,
  input  logic                pop,
  output logic                wr_enb,
  output logic                rd_enb,
  output logic [PTR_SIZE-1:0] wr_ptr,
  output logic [PTR_SIZE-1:0] rd_ptr,
  output logic [PTR_SIZE:0]   count,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                data_valid,
  output logic                error,
  output logic [2:0]          state
);
  typedef enum logic [2:0] {
    S_RESET  = 3'b000,
    S_INIT   = 3'b001,
    S_IDLE   = 3'b010,
    S_ACTIVE = 3'b011,
    S_ERROR  = 3'b100
  } state_t;
  state_t state_q, state_d;
  logic [PTR_SIZE-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_SIZE-1:0] th_af_q, th_af_d, th_ae_q, th_ae_d;
  logic [PTR_SIZE:0] count_q, count_d;
  logic data_valid_q, error_q, run, ovf, udf;
  assign full         = count_q == (PTR_SIZE+1)'(RAM_DEPTH);
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= {1'b0, th_af_q};
  assign almost_empty = count_q <= {1'b0, th_ae_q};
  // rst gates the enables combinationally so nothing is issued during reset
  always_comb begin
    run      = ~rst & (state_q == S_IDLE | state_q == S_ACTIVE);
    rd_enb   = run & pop & ~empty;
    wr_enb   = run & push & (~full | rd_enb);
    ovf      = run & push & full & ~pop;
    udf      = run & pop & empty;
    wr_ptr_d = wr_enb ? wr_ptr_q + PTR_SIZE'(1) : wr_ptr_q;
    rd_ptr_d = rd_enb ? rd_ptr_q + PTR_SIZE'(1) : rd_ptr_q;
    count_d  = (wr_enb & ~rd_enb) ? count_q + (PTR_SIZE+1)'(1) :
               (rd_enb & ~wr_enb) ? count_q - (PTR_SIZE+1)'(1) : count_q;
    th_af_d  = state_q == S_INIT ? th_af_in : th_af_q;
    th_ae_d  = state_q == S_INIT ? th_ae_in : th_ae_q;
    state_d  = state_q == S_RESET ? S_INIT :
               state_q == S_INIT  ? (init ? S_INIT : S_IDLE) :
               state_q == S_ERROR ? S_ERROR :
               (ovf | udf)        ? S_ERROR :
               (state_q == S_IDLE && init) ? S_INIT :
               count_d == '0      ? S_IDLE : S_ACTIVE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RESET;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_valid_q <= 1'b0;
      error_q      <= 1'b0;
      th_af_q      <= PTR_SIZE'(RAM_DEPTH - 2);
      th_ae_q      <= PTR_SIZE'(2);
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_valid_q <= rd_enb;
      error_q      <= error_q | ovf | udf;
      th_af_q      <= th_af_d;
      th_ae_q      <= th_ae_d;
    end
  end
  assign wr_ptr     = wr_ptr_q;
  assign rd_ptr     = rd_ptr_q;
  assign count      = count_q;
  assign data_valid = data_valid_q;
  assign error      = error_q;
  assign state      = state_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: vector table, directed corner sequences and random traffic against a queue-based FIFO model
module tb_fifo_ctrl;
  logic clk = 0;
  logic rst, init, push, pop, wr_enb, rd_enb, full, empty, almost_full, almost_empty, data_valid, error;
  logic [2:0] th_af_in, th_ae_in, wr_ptr, rd_ptr, state;
  logic [3:0] count;
  logic [7:0] din, ram_q;
  logic [7:0] mem [8];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(.RAM_DEPTH(8), .PTR_SIZE(3)) dut (
    .clk(clk), .rst(rst), .init(init), .th_af_in(th_af_in), .th_ae_in(th_ae_in),
    .push(push), .pop(pop), .wr_enb(wr_enb), .rd_enb(rd_enb), .wr_ptr(wr_ptr),
    .rd_ptr(rd_ptr), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .data_valid(data_valid),
    .error(error), .state(state)
  );

  // behavioural RAM with one-cycle registered read, read-before-write
  always @(posedge clk) begin
    if (wr_enb) mem[wr_ptr] <= din;
    if (rd_enb) ram_q <= mem[rd_ptr];
  end

  localparam int RST = 0, INI = 1, IDL = 2, ACT = 3, ERR = 4;
  int m_state, m_wp, m_rp, m_af, m_ae, m_rdata;
  bit m_dv, m_err;
  int q[$];
  logic s_wr, s_rd;

  typedef struct {
    logic r, i, pu, po;
    int st, cnt;
    logic fu, em, af, ae, er;
  } vec_t;
  vec_t tq[$];

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_state = RST; m_wp = 0; m_rp = 0; m_af = 6; m_ae = 2;
    m_dv = 0; m_err = 0; q.delete();
  endtask

  task automatic add(input logic r, i, pu, po, input int st, cnt,
                     input logic fu, em, af, ae, er);
    vec_t v;
    v = '{r, i, pu, po, st, cnt, fu, em, af, ae, er};
    tq.push_back(v);
  endtask

  task automatic cyc(input logic r, i, pu, po, input logic [2:0] af, ae, input logic [7:0] d);
    bit run, e_rd, e_wr, ovf, udf;
    int cnt;
    rst = r; init = i; push = pu; pop = po; th_af_in = af; th_ae_in = ae; din = d;
    #3;
    cnt  = q.size();
    run  = !r && (m_state == IDL || m_state == ACT);
    e_rd = run && po && cnt > 0;
    e_wr = run && pu && (cnt < 8 || e_rd);
    s_wr = wr_enb; s_rd = rd_enb;
    chk("state", state, m_state);
    chk("count", count, cnt);
    chk("wr_ptr", wr_ptr, m_wp);
    chk("rd_ptr", rd_ptr, m_rp);
    chk("full", full, cnt == 8);
    chk("empty", empty, cnt == 0);
    chk("almost_full", almost_full, cnt >= m_af);
    chk("almost_empty", almost_empty, cnt <= m_ae);
    chk("wr_enb", wr_enb, e_wr);
    chk("rd_enb", rd_enb, e_rd);
    chk("data_valid", data_valid, m_dv);
    chk("error", error, m_err);
    if (m_dv) chk("rdata", ram_q, m_rdata);
    @(posedge clk);
    if (r) model_reset();
    else begin
      ovf = run && pu && cnt == 8 && !po;
      udf = run && po && cnt == 0;
      if (e_rd) begin m_rdata = q.pop_front(); m_rp = (m_rp + 1) % 8; end
      if (e_wr) begin q.push_back(d); m_wp = (m_wp + 1) % 8; end
      m_dv = e_rd;
      m_err = m_err | ovf | udf;
      if (m_state == INI) begin m_af = af; m_ae = ae; end
      case (m_state)
        RST:     m_state = INI;
        INI:     m_state = i ? INI : IDL;
        ERR:     m_state = ERR;
        default: m_state = (ovf || udf) ? ERR : (m_state == IDL && i) ? INI :
                           (q.size() == 0 ? IDL : ACT);
      endcase
    end
    #1;
  endtask

  initial begin
    logic pu, po, r, i;
    rst = 1; init = 0; push = 0; pop = 0; th_af_in = 0; th_ae_in = 0; din = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    add(1,0,0,0, RST,0, 0,1,0,1,0);
    add(1,0,0,0, RST,0, 0,1,0,1,0);
    add(0,0,0,0, INI,0, 0,1,0,1,0);
    add(0,0,0,0, IDL,0, 0,1,0,1,0);
    for (int k = 1; k <= 8; k++) add(0,0,1,0, ACT,k, k == 8, 0, k >= 6, k <= 2, 0);
    add(0,0,1,0, ERR,8, 1,0,1,0,1);
    add(0,0,1,1, ERR,8, 1,0,1,0,1);
    add(1,0,0,0, RST,0, 0,1,0,1,0);
    add(0,0,0,0, INI,0, 0,1,0,1,0);
    add(0,0,0,0, IDL,0, 0,1,0,1,0);
    add(0,0,1,1, ERR,1, 0,0,0,1,1);
    add(1,0,0,0, RST,0, 0,1,0,1,0);
    add(0,0,0,0, INI,0, 0,1,0,1,0);
    add(0,0,0,0, IDL,0, 0,1,0,1,0);
    add(0,0,0,1, ERR,0, 0,1,0,1,1);
    add(1,0,0,0, RST,0, 0,1,0,1,0);
    foreach (tq[n]) begin
      cyc(tq[n].r, tq[n].i, tq[n].pu, tq[n].po, 3'd6, 3'd2, 8'(n));
      chk($sformatf("tbl%0d_state", n), state, tq[n].st);
      chk($sformatf("tbl%0d_count", n), count, tq[n].cnt);
      chk($sformatf("tbl%0d_full", n), full, tq[n].fu);
      chk($sformatf("tbl%0d_empty", n), empty, tq[n].em);
      chk($sformatf("tbl%0d_af", n), almost_full, tq[n].af);
      chk($sformatf("tbl%0d_ae", n), almost_empty, tq[n].ae);
      chk($sformatf("tbl%0d_error", n), error, tq[n].er);
    end
    // fill with 1..8, check wrap, then drain in order
    cyc(0,0,0,0, 3'd6, 3'd2, 0);
    cyc(0,0,0,0, 3'd6, 3'd2, 0);
    for (int k = 1; k <= 8; k++) begin
      cyc(0,0,1,0, 3'd6, 3'd2, 8'(k));
      if (k == 7) chk("fill_wr_ptr7", wr_ptr, 7);
    end
    chk("fill_wr_ptr_wrap", wr_ptr, 0);
    chk("fill_full", full, 1);
    for (int k = 1; k <= 8; k++) begin
      cyc(0,0,0,1, 3'd6, 3'd2, 0);
      chk("drain_dv", data_valid, 1);
      chk("drain_data", ram_q, k);
    end
    chk("drain_empty", empty, 1);
    chk("drain_rd_ptr", rd_ptr, 0);
    cyc(0,0,0,0, 3'd6, 3'd2, 0);
    chk("dv_drops", data_valid, 0);
    // simultaneous push/pop at full and at count 3
    for (int k = 1; k <= 8; k++) cyc(0,0,1,0, 3'd6, 3'd2, 8'(10 + k));
    cyc(0,0,1,1, 3'd6, 3'd2, 8'd99);
    chk("full_both_wr", s_wr, 1);
    chk("full_both_rd", s_rd, 1);
    chk("full_both_count", count, 8);
    chk("full_both_error", error, 0);
    chk("full_both_old", ram_q, 11);
    for (int k = 0; k < 5; k++) cyc(0,0,0,1, 3'd6, 3'd2, 0);
    cyc(0,0,1,1, 3'd6, 3'd2, 8'd77);
    chk("mid_both_wr", s_wr, 1);
    chk("mid_both_rd", s_rd, 1);
    chk("mid_both_count", count, 3);
    // reconfigure thresholds to 4/1
    for (int k = 0; k < 3; k++) cyc(0,0,0,1, 3'd6, 3'd2, 0);
    chk("reconf_idle", state, IDL);
    cyc(0,1,0,0, 3'd4, 3'd1, 0);
    chk("reconf_init", state, INI);
    cyc(0,0,0,0, 3'd4, 3'd1, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc(0,0,1,0, 3'd0, 3'd0, 8'(k));
      if (k == 3) chk("reconf_af3", almost_full, 0);
    end
    chk("reconf_af4", almost_full, 1);
    cyc(0,0,0,1, 3'd0, 3'd0, 0);
    cyc(0,0,0,1, 3'd0, 3'd0, 0);
    chk("reconf_ae2", almost_empty, 0);
    cyc(0,0,0,1, 3'd0, 3'd0, 0);
    chk("reconf_ae1", almost_empty, 1);
    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r  = (m_state == ERR && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0;
      i  = $urandom_range(0, 29) == 0 || (m_state == INI && $urandom_range(0, 1) == 1);
      pu = 1'($urandom_range(0, 1));
      po = 1'($urandom_range(0, 1));
      if (q.size() == 0 && po && $urandom_range(0, 19) != 0) po = 0;
      if (q.size() == 8 && pu && !po && $urandom_range(0, 19) != 0) pu = 0;
      cyc(r, i, pu, po, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
